spi_flash_responder: RTL and testbench

SPI-mode-0 flash target emulator running on `clk_48mhz`. It is the responder side of the bootloader's SPI flash master, used in FPGA-in-the-loop and simulation builds where a real flash part is absent. It oversamples `spi_cs`, `spi_sck` and `spi_mosi`, decodes the command subset the bootloader issues, and serves the flash array through a simple byte-wide memory port. It supports read, fast read, JEDEC ID, status, write enable/disable, page program, 4 KB erase, and power-down/release.

---
 rtl/spi_flash_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target emulator: oversampled SPI front end, command decoder
// and byte-wide memory port for read, program, erase, ID, status and power-down.
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic        clk_48mhz,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    output logic        mem_erase,
    output logic        powered_down
);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, STAT, JEDEC, IGNORE
    } state_t;

    state_t      state;
    logic [1:0]  cs_sync, sck_sync, mosi_sync;
    logic        cs_q, sck_q;
    logic        cs_s, sck_s, mosi_s;
    logic        cs_rise, cs_fall, sck_rise, sck_fall;
    logic [2:0]  bit_cnt;
    logic [5:0]  bit_total;
    logic [7:0]  rx_shift, rx_byte;
    logic [7:0]  tx_shift, tx_next, load_byte;
    logic        load_pending;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [1:0]  addr_cnt;
    logic [1:0]  id_idx;
    logic        wel, pd_pending;
    logic        rd_q;
    logic [7:0]  rdata_q;

    assign cs_s      = cs_sync[1];
    assign sck_s     = sck_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;
    assign sck_rise  = sck_s & ~sck_q;
    assign sck_fall  = ~sck_s & sck_q;
    assign rx_byte   = {rx_shift[6:0], mosi_s};
    assign load_byte = (state == RDATA) ? rdata_q : tx_next;

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            cs_sync   <= 2'b11;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], spi_cs};
            sck_sync  <= {sck_sync[0], spi_sck};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            cs_q      <= cs_s;
            sck_q     <= sck_s;
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state        <= IDLE;
            spi_miso     <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wdata    <= '0;
            mem_erase    <= 1'b0;
            powered_down <= 1'b0;
            bit_cnt      <= '0;
            bit_total    <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            tx_next      <= '0;
            load_pending <= 1'b0;
            cmd          <= '0;
            addr         <= '0;
            addr_cnt     <= '0;
            id_idx       <= '0;
            wel          <= 1'b0;
            pd_pending   <= 1'b0;
            rd_q         <= 1'b0;
            rdata_q      <= '0;
        end else begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_erase <= 1'b0;
            rd_q      <= mem_rd;
            if (rd_q)
                rdata_q <= mem_rdata;

            // cs rise is checked first so it overrides a byte completing in the same cycle
            if (cs_rise) begin
                state        <= IDLE;
                bit_cnt      <= '0;
                bit_total    <= '0;
                rx_shift     <= '0;
                tx_shift     <= '0;
                spi_miso     <= 1'b0;
                load_pending <= 1'b0;
                if (cmd == 8'h20 && wel && bit_total == 6'd32) begin
                    mem_erase <= 1'b1;
                    mem_addr  <= {addr[23:12], 12'h000};
                end
                if (cmd == 8'h02 || cmd == 8'h20)
                    wel <= 1'b0;
                if (pd_pending)
                    powered_down <= 1'b1;
                pd_pending <= 1'b0;
                cmd        <= '0;
            end else if (state == IDLE) begin
                if (cs_fall) begin
                    state     <= CMD;
                    bit_cnt   <= '0;
                    bit_total <= '0;
                    rx_shift  <= '0;
                    addr_cnt  <= '0;
                end
            end else if (sck_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte;
                if (bit_total != 6'h3F)
                    bit_total <= bit_total + 6'd1;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        CMD: begin
                            if (powered_down && rx_byte != 8'hAB) begin
                                state <= IGNORE;
                                cmd   <= 8'hFF;
                            end else begin
                                cmd   <= rx_byte;
                                state <= IGNORE;
                                case (rx_byte)
                                    8'h03, 8'h0B, 8'h02, 8'h20: begin
                                        state    <= ADDR;
                                        addr_cnt <= '0;
                                    end
                                    8'h9F: begin
                                        state        <= JEDEC;
                                        tx_next      <= JEDEC_ID[23:16];
                                        id_idx       <= 2'd1;
                                        load_pending <= 1'b1;
                                    end
                                    8'h05: begin
                                        state        <= STAT;
                                        tx_next      <= {6'b0, wel, 1'b0};
                                        load_pending <= 1'b1;
                                    end
                                    8'h06:   wel          <= 1'b1;
                                    8'h04:   wel          <= 1'b0;
                                    8'hB9:   pd_pending   <= 1'b1;
                                    8'hAB:   powered_down <= 1'b0;
                                    default: ;
                                endcase
                            end
                        end
                        ADDR: begin
                            addr     <= {addr[15:0], rx_byte};
                            addr_cnt <= addr_cnt + 2'd1;
                            if (addr_cnt == 2'd2) begin
                                case (cmd)
                                    8'h03: begin
                                        state        <= RDATA;
                                        mem_rd       <= 1'b1;
                                        mem_addr     <= {addr[15:0], rx_byte};
                                        load_pending <= 1'b1;
                                    end
                                    8'h0B:   state <= DUMMY;
                                    8'h02:   state <= WDATA;
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                        DUMMY: begin
                            state        <= RDATA;
                            mem_rd       <= 1'b1;
                            mem_addr     <= addr;
                            load_pending <= 1'b1;
                        end
                        RDATA: begin
                            addr         <= addr + 24'd1;
                            mem_rd       <= 1'b1;
                            mem_addr     <= addr + 24'd1;
                            load_pending <= 1'b1;
                        end
                        WDATA: begin
                            if (wel) begin
                                mem_wr    <= 1'b1;
                                mem_wdata <= rx_byte;
                                mem_addr  <= addr;
                            end
                            addr[7:0] <= addr[7:0] + 8'd1;
                        end
                        STAT: begin
                            tx_next      <= {6'b0, wel, 1'b0};
                            load_pending <= 1'b1;
                        end
                        JEDEC: begin
                            case (id_idx)
                                2'd1:    tx_next <= JEDEC_ID[15:8];
                                2'd2:    tx_next <= JEDEC_ID[7:0];
                                default: tx_next <= '0;
                            endcase
                            if (id_idx != 2'd3)
                                id_idx <= id_idx + 2'd1;
                            load_pending <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (sck_fall) begin
                if (state == RDATA || state == STAT || state == JEDEC) begin
                    if (load_pending) begin
                        tx_shift     <= load_byte;
                        spi_miso     <= load_byte[7];
                        load_pending <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        spi_miso <= tx_shift[6];
                    end
                end else begin
                    spi_miso <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: directed flash transactions plus
// random ones, checked against a transaction-level flash model.
module tb_spi_flash_responder;

    localparam int          HALF = 5;
    localparam logic [23:0] ID   = 24'hEF4016;

    logic        clk_48mhz = 1'b0;
    logic        reset     = 1'b1;
    logic        spi_cs    = 1'b1;
    logic        spi_sck   = 1'b0;
    logic        spi_mosi  = 1'b0;
    logic        spi_miso;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic        mem_erase;
    logic        powered_down;

    int n_checks = 0;
    int n_fail   = 0;

    logic        m_wel = 1'b0;
    logic        m_pd  = 1'b0;
    logic [23:0] exp_rd[$],  obs_rd[$];
    logic [31:0] exp_wr[$],  obs_wr[$];
    logic [23:0] exp_er[$],  obs_er[$];
    logic [7:0]  exp_miso[$];

    spi_flash_responder #(.JEDEC_ID(ID)) dut (
        .clk_48mhz   (clk_48mhz),
        .reset       (reset),
        .spi_cs      (spi_cs),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_erase   (mem_erase),
        .powered_down(powered_down)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    function automatic logic [7:0] mem_val(input logic [23:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Flash array: data valid for exactly one cycle after the strobe, junk otherwise
    always @(posedge clk_48mhz)
        mem_rdata <= mem_rd ? mem_val(mem_addr) : 8'($urandom);

    always @(negedge clk_48mhz) begin
        if (mem_rd)    obs_rd.push_back(mem_addr);
        if (mem_wr)    obs_wr.push_back({mem_addr, mem_wdata});
        if (mem_erase) obs_er.push_back(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_txn(input logic [7:0] tx[$], input int nbits);
        int          full;
        int          ds;
        logic [7:0]  op;
        logic [23:0] a;
        logic [23:0] idv;
        idv = ID;
        full = nbits / 8;
        exp_rd.delete(); exp_wr.delete(); exp_er.delete(); exp_miso.delete();
        for (int j = 0; j < full; j++) exp_miso.push_back(8'h00);
        if (full == 0) return;
        op = tx[0];
        a  = (tx.size() >= 4) ? {tx[1], tx[2], tx[3]} : 24'h0;
        if (m_pd && op != 8'hAB) return;
        case (op)
            8'h03, 8'h0B: begin
                ds = (op == 8'h03) ? 4 : 5;
                if (full >= ds) begin
                    for (int k = 0; k <= full - ds; k++) exp_rd.push_back(a + 24'(k));
                    for (int j = ds; j < full; j++) exp_miso[j] = mem_val(a + 24'(j - ds));
                end
            end
            8'h02: begin
                if (m_wel)
                    for (int j = 4; j < full; j++)
                        exp_wr.push_back({a[23:8], a[7:0] + 8'(j - 4), tx[j]});
                m_wel = 1'b0;
            end
            8'h20: begin
                if (m_wel && nbits == 32) exp_er.push_back({a[23:12], 12'h000});
                m_wel = 1'b0;
            end
            8'h9F: for (int j = 1; j < full; j++)
                exp_miso[j] = (j == 1) ? idv[23:16] : (j == 2) ? idv[15:8] :
                              (j == 3) ? idv[7:0] : 8'h00;
            8'h05: for (int j = 1; j < full; j++) exp_miso[j] = {6'b0, m_wel, 1'b0};
            8'h06: m_wel = 1'b1;
            8'h04: m_wel = 1'b0;
            8'hB9: m_pd  = 1'b1;
            8'hAB: m_pd  = 1'b0;
            default: ;
        endcase
    endtask

    task automatic spi_xfer(input logic [7:0] tx[$], input int nbits, input bit hold,
                            output logic [7:0] rx[$]);
        logic [7:0] cur;
        logic [7:0] sh;
        rx = {};
        sh = '0;
        @(negedge clk_48mhz);
        spi_cs = 1'b0;
        repeat (HALF) @(negedge clk_48mhz);
        for (int i = 0; i < nbits; i++) begin
            cur = tx[i / 8];
            spi_mosi = cur[7 - (i % 8)];
            repeat (HALF) @(negedge clk_48mhz);
            spi_sck = 1'b1;
            sh = {sh[6:0], spi_miso};
            if (i % 8 == 7) rx.push_back(sh);
            repeat (HALF) @(negedge clk_48mhz);
            spi_sck = 1'b0;
        end
        if (!hold) begin
            repeat (HALF) @(negedge clk_48mhz);
            spi_cs   = 1'b1;
            spi_mosi = 1'b0;
            repeat (12) @(negedge clk_48mhz);
        end
    endtask

    task automatic run_txn(input logic [7:0] tx[$], input int nbits);
        logic [7:0] rx[$];
        model_txn(tx, nbits);
        obs_rd.delete(); obs_wr.delete(); obs_er.delete();
        spi_xfer(tx, nbits, 1'b0, rx);
        for (int j = 0; j < exp_miso.size(); j++)
            check($sformatf("miso[%0d] op %h", j, tx[0]), 32'(rx[j]), 32'(exp_miso[j]));
        check("rd_count", 32'(obs_rd.size()), 32'(exp_rd.size()));
        for (int j = 0; j < exp_rd.size() && j < obs_rd.size(); j++)
            check("rd_addr", 32'(obs_rd[j]), 32'(exp_rd[j]));
        check("wr_count", 32'(obs_wr.size()), 32'(exp_wr.size()));
        for (int j = 0; j < exp_wr.size() && j < obs_wr.size(); j++)
            check("wr_addr_data", obs_wr[j], exp_wr[j]);
        check("erase_count", 32'(obs_er.size()), 32'(exp_er.size()));
        for (int j = 0; j < exp_er.size() && j < obs_er.size(); j++)
            check("erase_addr", 32'(obs_er[j]), 32'(exp_er[j]));
        check("powered_down", 32'(powered_down), 32'(m_pd));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},  32'(spi_miso),     32'h0);
        check({tag, "_addr"},  32'(mem_addr),     32'h0);
        check({tag, "_rd"},    32'(mem_rd),       32'h0);
        check({tag, "_wr"},    32'(mem_wr),       32'h0);
        check({tag, "_wdata"}, 32'(mem_wdata),    32'h0);
        check({tag, "_erase"}, 32'(mem_erase),    32'h0);
        check({tag, "_pd"},    32'(powered_down), 32'h0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] rx[$];
        logic [7:0] ops[12];
        logic [23:0] a;
        int nd;
        int nbits;

        ops = '{8'h03, 8'h0B, 8'h02, 8'h20, 8'h9F, 8'h05, 8'h06, 8'h06, 8'h04, 8'hB9, 8'hAB, 8'h00};
        repeat (5) @(negedge clk_48mhz);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk_48mhz);

        q = {8'h9F, 8'h00, 8'h00, 8'h00, 8'h00};        run_txn(q, 40);
        q = {8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}; run_txn(q, 56);
        q = {8'h0B, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00}; run_txn(q, 56);
        q = {8'h02, 8'h00, 8'h12, 8'hFE, 8'hAA, 8'hBB, 8'hCC}; run_txn(q, 56);
        q = {8'h06};                                     run_txn(q, 8);
        q = {8'h02, 8'h00, 8'h12, 8'hFE, 8'hAA, 8'hBB, 8'hCC}; run_txn(q, 56);
        q = {8'h05, 8'h00};                              run_txn(q, 16);
        q = {8'h06};                                     run_txn(q, 8);
        q = {8'h05, 8'h00, 8'h00};                       run_txn(q, 24);
        q = {8'h20, 8'h01, 8'h23, 8'h45};                run_txn(q, 32);
        q = {8'h06};                                     run_txn(q, 8);
        q = {8'h20, 8'h01, 8'h23, 8'h45};                run_txn(q, 28);
        q = {8'h05, 8'h00};                              run_txn(q, 16);
        q = {8'hB9};                                     run_txn(q, 8);
        q = {8'h03, 8'h00, 8'h00, 8'h40, 8'h00};         run_txn(q, 40);
        q = {8'hAB};                                     run_txn(q, 8);
        q = {8'h03, 8'h00, 8'h00, 8'h40, 8'h00};         run_txn(q, 40);
        q = {8'h06};                                     run_txn(q, 8);
        q = {8'h03, 8'h00, 8'h02, 8'h00};                run_txn(q, 20);
        q = {8'h05, 8'h00};                              run_txn(q, 16);

        // Reset in the middle of a read data byte
        q = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
        spi_xfer(q, 44, 1'b1, rx);
        @(negedge clk_48mhz);
        reset = 1'b1;
        @(negedge clk_48mhz);
        check_reset_outputs("midread_reset");
        spi_cs  = 1'b1;
        spi_sck = 1'b0;
        repeat (6) @(negedge clk_48mhz);
        reset = 1'b0;
        m_wel = 1'b0;
        m_pd  = 1'b0;
        repeat (6) @(negedge clk_48mhz);
        q = {8'h05, 8'h00};                              run_txn(q, 16);

        for (int t = 0; t < 40; t++) begin
            q = {};
            q.push_back(ops[$urandom_range(0, 11)]);
            if (q[0] == 8'h00) q[0] = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 24'hFFFFF0 | 24'($urandom_range(0, 15));
                1:       a = {16'($urandom), 8'hF0 | 8'($urandom_range(0, 15))};
                default: a = 24'($urandom);
            endcase
            q.push_back(a[23:16]);
            q.push_back(a[15:8]);
            q.push_back(a[7:0]);
            nd = $urandom_range(0, 4);
            for (int j = 0; j < nd; j++) q.push_back(8'($urandom));
            nbits = 8 * q.size();
            if ($urandom_range(0, 4) == 0) nbits = $urandom_range(1, 8 * q.size() - 1);
            run_txn(q, nbits);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
